// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - Y86-64 memory stage: E->M pipeline register plus byte-addressed data memory
module memory_stage #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        M_bubble,
    input  logic [2:0]  e_stat,
    input  logic [3:0]  e_icode,
    input  logic        e_Cnd,
    input  logic [63:0] e_valE,
    input  logic [63:0] e_valA,
    input  logic [3:0]  e_dstE,
    input  logic [3:0]  e_dstM,
    output logic [2:0]  M_stat,
    output logic [3:0]  M_icode,
    output logic        M_Cnd,
    output logic [63:0] M_valE,
    output logic [63:0] M_valA,
    output logic [3:0]  M_dstE,
    output logic [3:0]  M_dstM,
    output logic [2:0]  m_stat,
    output logic [63:0] m_valM,
    output logic        m_dmem_error
);

    localparam int AW = $clog2(MEM_BYTES);
    localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES - 8);

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_ADR = 3'd2;

    localparam logic [3:0] I_NOP    = 4'd1;
    localparam logic [3:0] I_RMMOVQ = 4'd4;
    localparam logic [3:0] I_MRMOVQ = 4'd5;
    localparam logic [3:0] I_CALL   = 4'd8;
    localparam logic [3:0] I_RET    = 4'd9;
    localparam logic [3:0] I_PUSHQ  = 4'd10;
    localparam logic [3:0] I_POPQ   = 4'd11;
    localparam logic [3:0] R_NONE   = 4'd15;

    logic [2:0]  stat_q,  stat_d;
    logic [3:0]  icode_q, icode_d;
    logic        cnd_q,   cnd_d;
    logic [63:0] vale_q,  vale_d;
    logic [63:0] vala_q,  vala_d;
    logic [3:0]  dste_q,  dste_d;
    logic [3:0]  dstm_q,  dstm_d;

    logic [7:0]    mem_q [MEM_BYTES];
    logic [63:0]   addr;
    logic          rd_en;
    logic          wr_en;
    logic          fault;
    logic          wr_ok;
    logic [AW-1:0] idx;
    logic [63:0]   rdata;

    // A bubble injects the same NOP state that reset produces.
    always_comb begin
        stat_d  = e_stat;
        icode_d = e_icode;
        cnd_d   = e_Cnd;
        vale_d  = e_valE;
        vala_d  = e_valA;
        dste_d  = e_dstE;
        dstm_d  = e_dstM;
        if (M_bubble) begin
            stat_d  = STAT_AOK;
            icode_d = I_NOP;
            cnd_d   = 1'b0;
            vale_d  = 64'd0;
            vala_d  = 64'd0;
            dste_d  = R_NONE;
            dstm_d  = R_NONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_q  <= STAT_AOK;
            icode_q <= I_NOP;
            cnd_q   <= 1'b0;
            vale_q  <= 64'd0;
            vala_q  <= 64'd0;
            dste_q  <= R_NONE;
            dstm_q  <= R_NONE;
        end else begin
            stat_q  <= stat_d;
            icode_q <= icode_d;
            cnd_q   <= cnd_d;
            vale_q  <= vale_d;
            vala_q  <= vala_d;
            dste_q  <= dste_d;
            dstm_q  <= dstm_d;
        end
    end

    always_comb begin
        addr  = 64'd0;
        rd_en = 1'b0;
        wr_en = 1'b0;
        case (icode_q)
            I_RMMOVQ, I_CALL, I_PUSHQ: begin
                addr  = vale_q;
                wr_en = 1'b1;
            end
            I_MRMOVQ: begin
                addr  = vale_q;
                rd_en = 1'b1;
            end
            I_RET, I_POPQ: begin
                addr  = vala_q;
                rd_en = 1'b1;
            end
            default: ;
        endcase
    end

    // Unsigned compare so wrapped addresses near 2^64 also fault.
    assign fault = (rd_en || wr_en) && (addr > MAX_ADDR);
    assign wr_ok = wr_en && !fault && (stat_q == STAT_AOK);
    assign idx   = addr[AW-1:0];

    always_comb begin
        rdata = 64'd0;
        if (rd_en && !fault) begin
            for (int k = 0; k < 8; k++) begin
                rdata[8*k +: 8] = mem_q[idx + AW'(k)];
            end
        end
    end

    // Memory has no reset; an edge seen while rst is high never writes.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            for (int k = 0; k < 8; k++) begin
                mem_q[idx + AW'(k)] <= vala_q[8*k +: 8];
            end
        end
    end

    assign M_stat       = stat_q;
    assign M_icode      = icode_q;
    assign M_Cnd        = cnd_q;
    assign M_valE       = vale_q;
    assign M_valA       = vala_q;
    assign M_dstE       = dste_q;
    assign M_dstM       = dstm_q;
    assign m_dmem_error = fault;
    assign m_stat       = fault ? STAT_ADR : stat_q;
    assign m_valM       = rdata;

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - directed self-checking bench for memory_stage
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        M_bubble;
    logic [2:0]  e_stat;
    logic [3:0]  e_icode;
    logic        e_Cnd;
    logic [63:0] e_valE;
    logic [63:0] e_valA;
    logic [3:0]  e_dstE;
    logic [3:0]  e_dstM;
    logic [2:0]  M_stat;
    logic [3:0]  M_icode;
    logic        M_Cnd;
    logic [63:0] M_valE;
    logic [63:0] M_valA;
    logic [3:0]  M_dstE;
    logic [3:0]  M_dstM;
    logic [2:0]  m_stat;
    logic [63:0] m_valM;
    logic        m_dmem_error;

    int total = 0;
    int bad   = 0;

    memory_stage #(.MEM_BYTES(1024)) dut (
        .clk(clk), .rst(rst), .M_bubble(M_bubble),
        .e_stat(e_stat), .e_icode(e_icode), .e_Cnd(e_Cnd),
        .e_valE(e_valE), .e_valA(e_valA), .e_dstE(e_dstE), .e_dstM(e_dstM),
        .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd),
        .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
        .m_stat(m_stat), .m_valM(m_valM), .m_dmem_error(m_dmem_error)
    );

    always #5 clk = ~clk;

    // Present one instruction on e_*, clock it into M, then settle.
    task automatic issue(input logic [2:0] st, input logic [3:0] ic,
                         input logic [63:0] ve, input logic [63:0] va,
                         input logic [3:0] de, input logic [3:0] dm);
        e_stat  = st;
        e_icode = ic;
        e_Cnd   = 1'b0;
        e_valE  = ve;
        e_valA  = va;
        e_dstE  = de;
        e_dstM  = dm;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        M_bubble = 1'b0;
        e_stat = 3'd1; e_icode = 4'd0; e_Cnd = 1'b1;
        e_valE = 64'd5; e_valA = 64'd6; e_dstE = 4'd2; e_dstM = 4'd3;
        repeat (2) @(posedge clk);
        #1;
        total++; if (M_stat !== 3'd1) begin bad++; $display("FAIL reset_M_stat got=%0d exp=1", M_stat); end
        total++; if (M_icode !== 4'd1) begin bad++; $display("FAIL reset_M_icode got=%0d exp=1", M_icode); end
        total++; if (M_Cnd !== 1'b0) begin bad++; $display("FAIL reset_M_Cnd got=%0b exp=0", M_Cnd); end
        total++; if (M_valE !== 64'd0 || M_valA !== 64'd0) begin bad++; $display("FAIL reset_vals got=%h/%h exp=0/0", M_valE, M_valA); end
        total++; if (M_dstE !== 4'd15 || M_dstM !== 4'd15) begin bad++; $display("FAIL reset_dst got=%0d/%0d exp=15/15", M_dstE, M_dstM); end
        total++; if (m_stat !== 3'd1 || m_valM !== 64'd0 || m_dmem_error !== 1'b0) begin bad++; $display("FAIL reset_mout got=%0d/%h/%0b exp=1/0/0", m_stat, m_valM, m_dmem_error); end
        rst = 1'b0;
    endtask

    task automatic test_store_load;
        issue(3'd1, 4'd4, 64'h40, 64'h1122334455667788, 4'd15, 4'd15);
        total++; if (m_stat !== 3'd1 || m_valM !== 64'd0 || m_dmem_error !== 1'b0) begin bad++; $display("FAIL st_mout got=%0d/%h/%0b exp=1/0/0", m_stat, m_valM, m_dmem_error); end
        issue(3'd1, 4'd5, 64'h40, 64'd0, 4'd15, 4'd2);
        total++; if (m_valM !== 64'h1122334455667788) begin bad++; $display("FAIL ld_valM got=%h exp=1122334455667788", m_valM); end
        total++; if (m_valM[7:0] !== 8'h88) begin bad++; $display("FAIL ld_byte40 got=%h exp=88", m_valM[7:0]); end
        issue(3'd1, 4'd5, 64'h41, 64'd0, 4'd15, 4'd2);
        total++; if (m_valM[55:0] !== 56'h11223344556677) begin bad++; $display("FAIL ld_unaligned got=%h exp=11223344556677", m_valM[55:0]); end
    endtask

    task automatic test_push_pop;
        issue(3'd1, 4'd10, 64'h1F8, 64'hABCD, 4'd4, 4'd15);
        issue(3'd1, 4'd11, 64'h200, 64'h1F8, 4'd4, 4'd3);
        total++; if (m_valM !== 64'hABCD) begin bad++; $display("FAIL pop_valM got=%h exp=abcd", m_valM); end
        total++; if (m_stat !== 3'd1) begin bad++; $display("FAIL pop_stat got=%0d exp=1", m_stat); end
        total++; if (M_dstM !== 4'd3 || M_dstE !== 4'd4) begin bad++; $display("FAIL pop_dst got=%0d/%0d exp=3/4", M_dstM, M_dstE); end
        // ret reads its address from valA
        issue(3'd1, 4'd9, 64'h0, 64'h40, 4'd4, 4'd15);
        total++; if (m_valM !== 64'h1122334455667788) begin bad++; $display("FAIL ret_valM got=%h exp=1122334455667788", m_valM); end
    endtask

    task automatic test_fault;
        issue(3'd1, 4'd4, 64'd1016, 64'h0102030405060708, 4'd15, 4'd15);
        issue(3'd1, 4'd5, 64'd1016, 64'd0, 4'd15, 4'd1);
        total++; if (m_dmem_error !== 1'b0 || m_valM !== 64'h0102030405060708) begin bad++; $display("FAIL edge_ok got=%0b/%h exp=0/0102030405060708", m_dmem_error, m_valM); end
        issue(3'd1, 4'd5, 64'd1017, 64'd0, 4'd15, 4'd1);
        total++; if (m_dmem_error !== 1'b1) begin bad++; $display("FAIL fault_err got=%0b exp=1", m_dmem_error); end
        total++; if (m_stat !== 3'd2) begin bad++; $display("FAIL fault_stat got=%0d exp=2", m_stat); end
        total++; if (m_valM !== 64'd0) begin bad++; $display("FAIL fault_valM got=%h exp=0", m_valM); end
        issue(3'd1, 4'd4, 64'hFFFF_FFFF_FFFF_FFF8, 64'hDEADBEEFDEADBEEF, 4'd15, 4'd15);
        total++; if (m_stat !== 3'd2 || m_dmem_error !== 1'b1) begin bad++; $display("FAIL wrap_stat got=%0d/%0b exp=2/1", m_stat, m_dmem_error); end
        issue(3'd1, 4'd5, 64'd1016, 64'd0, 4'd15, 4'd1);
        total++; if (m_valM !== 64'h0102030405060708) begin bad++; $display("FAIL wrap_nowrite got=%h exp=0102030405060708", m_valM); end
    endtask

    task automatic test_bubble;
        issue(3'd1, 4'd4, 64'h80, 64'h5555, 4'd15, 4'd15);
        M_bubble = 1'b1;
        issue(3'd1, 4'd4, 64'h80, 64'h9999, 4'd5, 4'd6);
        M_bubble = 1'b0;
        total++; if (M_icode !== 4'd1 || M_stat !== 3'd1) begin bad++; $display("FAIL bub_icode got=%0d/%0d exp=1/1", M_icode, M_stat); end
        total++; if (M_dstE !== 4'd15 || M_dstM !== 4'd15 || M_valE !== 64'd0) begin bad++; $display("FAIL bub_regs got=%0d/%0d/%h exp=15/15/0", M_dstE, M_dstM, M_valE); end
        issue(3'd1, 4'd5, 64'h80, 64'd0, 4'd15, 4'd1);
        total++; if (m_valM !== 64'h5555) begin bad++; $display("FAIL bub_nowrite got=%h exp=5555", m_valM); end
    endtask

    task automatic test_status_gate;
        issue(3'd1, 4'd4, 64'hA0, 64'h77, 4'd15, 4'd15);
        issue(3'd3, 4'd4, 64'hA0, 64'h1234, 4'd15, 4'd15);
        total++; if (m_stat !== 3'd3 || m_dmem_error !== 1'b0) begin bad++; $display("FAIL ins_stat got=%0d/%0b exp=3/0", m_stat, m_dmem_error); end
        issue(3'd1, 4'd5, 64'hA0, 64'd0, 4'd15, 4'd1);
        total++; if (m_valM !== 64'h77) begin bad++; $display("FAIL ins_nowrite got=%h exp=77", m_valM); end
        issue(3'd4, 4'd0, 64'h40, 64'h40, 4'd15, 4'd15);
        total++; if (m_stat !== 3'd4 || m_valM !== 64'd0) begin bad++; $display("FAIL hlt_pass got=%0d/%h exp=4/0", m_stat, m_valM); end
        issue(3'd1, 4'd6, 64'h40, 64'h40, 4'd15, 4'd15);
        total++; if (m_stat !== 3'd1 || m_valM !== 64'd0 || m_dmem_error !== 1'b0) begin bad++; $display("FAIL unused_icode got=%0d/%h/%0b exp=1/0/0", m_stat, m_valM, m_dmem_error); end
    endtask

    task automatic test_reset_mid;
        issue(3'd1, 4'd4, 64'hC0, 64'h4242, 4'd15, 4'd15);
        issue(3'd1, 4'd4, 64'hC0, 64'hBAD, 4'd7, 4'd8);
        #2;
        rst = 1'b1;
        #1;
        total++; if (M_icode !== 4'd1) begin bad++; $display("FAIL async_icode got=%0d exp=1", M_icode); end
        total++; if (M_dstE !== 4'd15 || M_dstM !== 4'd15) begin bad++; $display("FAIL async_dst got=%0d/%0d exp=15/15", M_dstE, M_dstM); end
        @(posedge clk);
        #2;
        rst = 1'b0;
        issue(3'd1, 4'd5, 64'hC0, 64'd0, 4'd15, 4'd1);
        total++; if (m_valM !== 64'h4242) begin bad++; $display("FAIL async_nowrite got=%h exp=4242", m_valM); end
    endtask

    task automatic test_back_to_back;
        issue(3'd1, 4'd8, 64'h100, 64'h1111, 4'd4, 4'd15);
        issue(3'd1, 4'd10, 64'h108, 64'h2222, 4'd4, 4'd15);
        issue(3'd1, 4'd5, 64'h100, 64'd0, 4'd15, 4'd1);
        total++; if (m_valM !== 64'h1111) begin bad++; $display("FAIL b2b_first got=%h exp=1111", m_valM); end
        issue(3'd1, 4'd11, 64'h110, 64'h108, 4'd4, 4'd2);
        total++; if (m_valM !== 64'h2222) begin bad++; $display("FAIL b2b_second got=%h exp=2222", m_valM); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_push_pop();
        test_fault();
        test_bubble();
        test_status_gate();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
